// File: rtl/central_diff_iy_stream.sv
// central_diff_iy_stream
//   Streaming vertical central-difference gradient Iy(x,y) = (P(x,y+1) - P(x,y-1)) / 2
//   over a raster pixel stream. Two IMG_W-deep line buffers hold rows y and y-1, so
//   the output for row y-1 is produced as each pixel of row y arrives. The last row
//   is emitted by a flush pass once the final pixel of the frame has been accepted.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   pixel_in            unsigned raster pixel (PIX_W bits)
//   in_valid, in_sof    pixel valid; start-of-frame marker qualified by in_valid
//   in_ready            pixel accepted this cycle when in_valid & in_ready
//   pixel_Iy            signed gradient (OUT_W bits)
//   out_valid           pixel_Iy valid
//   out_sof, out_eof    first / last output pixel of a frame
//   err_sof             one-cycle pulse when in_sof is accepted mid-frame
//
// BORDER_MODE 0 outputs 0 on rows 0 and IMG_H-1; BORDER_MODE 1 replicates the edge row.

module central_diff_iy_stream #(
    parameter int unsigned PIX_W       = 12,
    parameter int unsigned OUT_W       = 16,
    parameter int unsigned IMG_W       = 640,
    parameter int unsigned IMG_H       = 480,
    parameter int unsigned BORDER_MODE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PIX_W-1:0]        pixel_in,
    input  logic                    in_valid,
    input  logic                    in_sof,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] pixel_Iy,
    output logic                    out_valid,
    output logic                    out_sof,
    output logic                    out_eof,
    output logic                    err_sof
);

    localparam int unsigned   CW       = $clog2(IMG_W);
    localparam int unsigned   RW       = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Line buffers are plain storage; they are never cleared.
    logic [PIX_W-1:0] lb_cur [IMG_W];
    logic [PIX_W-1:0] lb_prv [IMG_W];

    logic                    accept;
    logic                    sof_acc;
    logic                    col_last;
    logic                    row_last;
    logic [PIX_W-1:0]        rd_cur;
    logic [PIX_W-1:0]        rd_prv;
    logic [CW-1:0]           wr_col;
    logic                    cur_we;
    logic                    prv_we;
    logic signed [OUT_W-1:0] run_val;
    logic signed [OUT_W-1:0] flush_val;

    // (a - b) >>> 1 at PIX_W+1 bits, sign-extended to OUT_W (floor toward -inf).
    function automatic logic signed [OUT_W-1:0] half_diff(input logic [PIX_W-1:0] a,
                                                          input logic [PIX_W-1:0] b);
        logic signed [PIX_W:0] d;
        d = signed'({1'b0, a}) - signed'({1'b0, b});
        return OUT_W'(d >>> 1);
    endfunction

    always_comb begin
        accept   = in_valid & in_ready;
        sof_acc  = accept & in_sof;
        col_last = (col == COL_LAST);
        row_last = (row == ROW_LAST);
        rd_cur   = lb_cur[col];
        rd_prv   = lb_prv[col];
        wr_col   = in_sof ? '0 : col;
        cur_we   = accept & (in_sof | (state == FILL) | (state == RUN));
        prv_we   = accept & ~in_sof & (state == RUN);

        // Output row is row-1; row 0 has no previous row to subtract.
        if (row == ROW_ONE) begin
            run_val = (BORDER_MODE == 0) ? '0 : half_diff(pixel_in, rd_cur);
        end else begin
            run_val = half_diff(pixel_in, rd_prv);
        end
        flush_val = (BORDER_MODE == 0) ? '0 : half_diff(rd_cur, rd_prv);

        state_nx = state;
        case (state)
            IDLE:    if (sof_acc) state_nx = FILL;
            FILL: begin
                if (sof_acc)                 state_nx = FILL;
                else if (accept && col_last) state_nx = RUN;
            end
            RUN: begin
                if (sof_acc)                             state_nx = FILL;
                else if (accept && col_last && row_last) state_nx = FLUSH;
            end
            FLUSH:   if (col_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cur_we) lb_cur[wr_col] <= pixel_in;
        if (prv_we) lb_prv[col]    <= rd_cur;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            in_ready  <= 1'b1;
            pixel_Iy  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            err_sof   <= 1'b0;
        end else begin
            state     <= state_nx;
            // Registered from the next-state decode so in_ready is low for the
            // whole flush, starting the cycle after the last pixel is taken.
            in_ready  <= (state_nx != FLUSH);
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            err_sof   <= 1'b0;
            if (sof_acc) begin
                // A start marker always restarts at row 0 col 1 (col 0 written
                // above); outside IDLE it aborts the frame in progress.
                col     <= CW'(1);
                row     <= '0;
                err_sof <= (state != IDLE);
            end else begin
                case (state)
                    FILL: begin
                        if (accept) begin
                            if (col_last) begin
                                col <= '0;
                                row <= ROW_ONE;
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            out_valid <= 1'b1;
                            out_sof   <= (row == ROW_ONE) && (col == '0);
                            pixel_Iy  <= run_val;
                            if (col_last) begin
                                col <= '0;
                                if (!row_last) row <= row + RW'(1);
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    FLUSH: begin
                        out_valid <= 1'b1;
                        out_eof   <= col_last;
                        pixel_Iy  <= flush_val;
                        if (col_last) begin
                            col <= '0;
                            row <= '0;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_central_diff_iy_stream.sv
// Self-checking bench for central_diff_iy_stream: two instances (BORDER_MODE 0 and 1)
// on a 4x3 image share one input stream; outputs are compared with a frame-level
// gradient model computed directly from the stored frame.

module tb_central_diff_iy_stream;

    localparam int W = 4;
    localparam int H = 3;

    typedef struct packed {
        logic [15:0] v;
        logic        sof;
        logic        eof;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] pixel_in;
    logic        in_valid;
    logic        in_sof;

    logic               rdy0, ov0, osof0, oeof0, err0;
    logic               rdy1, ov1, osof1, oeof1, err1;
    logic signed [15:0] iy0, iy1;

    central_diff_iy_stream #(.PIX_W(12), .OUT_W(16), .IMG_W(W), .IMG_H(H), .BORDER_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(rdy0), .pixel_Iy(iy0), .out_valid(ov0), .out_sof(osof0), .out_eof(oeof0),
        .err_sof(err0)
    );

    central_diff_iy_stream #(.PIX_W(12), .OUT_W(16), .IMG_W(W), .IMG_H(H), .BORDER_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(rdy1), .pixel_Iy(iy1), .out_valid(ov1), .out_sof(osof1), .out_eof(oeof1),
        .err_sof(err1)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   frm [H][W];
    obs_t cap0[$], cap1[$], exp0[$], exp1[$];
    int   errc0, errc1, low0, low1, acc_cnt, acc_neg, first0, first1;
    int   ncyc = 0;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (ov0) cap0.push_back('{v: iy0, sof: osof0, eof: oeof0});
        if (ov1) cap1.push_back('{v: iy1, sof: osof1, eof: oeof1});
        if (err0) errc0++;
        if (err1) errc1++;
        if (!rdy0) low0++;
        if (!rdy1) low1++;
        if (in_valid && rdy0 && rdy1) begin
            if (acc_cnt == W) acc_neg = ncyc;
            acc_cnt++;
        end
        if (ov0 && first0 < 0) first0 = ncyc;
        if (ov1 && first1 < 0) first1 = ncyc;
        ncyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int floor_half(input int d);
        return (d < 0) ? -((-d + 1) / 2) : d / 2;
    endfunction

    function automatic obs_t model(input int mode, input int r, input int c);
        obs_t o;
        int   prv, nxt, v;
        if (mode == 0 && (r == 0 || r == H - 1)) begin
            v = 0;
        end else begin
            prv = (r == 0) ? frm[r][c] : frm[r-1][c];
            nxt = (r == H - 1) ? frm[r][c] : frm[r+1][c];
            v   = floor_half(nxt - prv);
        end
        o.v   = 16'(v);
        o.sof = (r == 0 && c == 0);
        o.eof = (r == H - 1 && c == W - 1);
        return o;
    endfunction

    task automatic clear_mon();
        cap0.delete(); cap1.delete(); exp0.delete(); exp1.delete();
        errc0 = 0; errc1 = 0; low0 = 0; low1 = 0;
        acc_cnt = 0; acc_neg = -1; first0 = -1; first1 = -1;
    endtask

    task automatic push_exp(input int r, input int c);
        exp0.push_back(model(0, r, c));
        exp1.push_back(model(1, r, c));
    endtask

    task automatic rand_frame();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frm[r][c] = int'($urandom_range(0, 4095));
    endtask

    task automatic row_frame(input int a, input int b, input int c2);
        for (int c = 0; c < W; c++) begin
            frm[0][c] = a; frm[1][c] = b; frm[2][c] = c2;
        end
    endtask

    // Called and returns at 1 time unit after a rising edge.
    task automatic send_pixel(input int p, input bit sof, input bit gaps);
        int  guard = 0;
        bit  acc;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_sof   = 1'($urandom);
                pixel_in = 12'($urandom);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_sof   = sof;
        pixel_in = 12'(p);
        forever begin
            acc = rdy0 & rdy1;
            @(posedge clk); #1;
            if (acc) break;
            guard++;
            if (guard > 50) begin
                chk("in_ready_timeout", {31'b0, rdy0 & rdy1}, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input bit junk);
        int g = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) send_pixel(frm[r][c], (r == 0 && c == 0), gaps);
        if (junk) begin
            // Offered while in_ready is low during the flush; must be ignored.
            while (!(rdy0 & rdy1) && g < 20) begin
                in_valid = 1'b1;
                in_sof   = 1'b1;
                pixel_in = 12'($urandom);
                @(posedge clk); #1;
                g++;
            end
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic compare_caps(input string tag);
        chk({tag, "_count0"}, cap0.size(), exp0.size());
        chk({tag, "_count1"}, cap1.size(), exp1.size());
        for (int i = 0; i < exp0.size() && i < cap0.size(); i++)
            chk($sformatf("%s_d0_out%0d", tag, i), 32'(cap0[i]), 32'(exp0[i]));
        for (int i = 0; i < exp1.size() && i < cap1.size(); i++)
            chk($sformatf("%s_d1_out%0d", tag, i), 32'(cap1[i]), 32'(exp1[i]));
    endtask

    task automatic run_frame(input string tag, input bit gaps, input bit junk);
        clear_mon();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) push_exp(r, c);
        send_frame(gaps, junk);
        repeat (8) @(posedge clk);
        #1;
        compare_caps(tag);
        chk({tag, "_err0"}, errc0, 0);
        chk({tag, "_err1"}, errc1, 0);
        chk({tag, "_rdylow0"}, low0, W);
        chk({tag, "_rdylow1"}, low1, W);
        chk({tag, "_lat0"}, first0 - acc_neg, 1);
        chk({tag, "_lat1"}, first1 - acc_neg, 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_d0"}, {11'b0, rdy0, ov0, osof0, oeof0, err0, iy0}, 32'h0010_0000);
        chk({tag, "_d1"}, {11'b0, rdy1, ov1, osof1, oeof1, err1, iy1}, 32'h0010_0000);
    endtask

    task automatic check_rows(input string tag, input int m0r0, input int m0r1, input int m0r2,
                              input int m1r0, input int m1r1, input int m1r2);
        int m0 [H];
        int m1 [H];
        m0[0] = m0r0; m0[1] = m0r1; m0[2] = m0r2;
        m1[0] = m1r0; m1[1] = m1r1; m1[2] = m1r2;
        for (int i = 0; i < W * H && i < cap0.size(); i++)
            chk($sformatf("%s_m0_%0d", tag, i), cap0[i].v, 16'(m0[i / W]));
        for (int i = 0; i < W * H && i < cap1.size(); i++)
            chk($sformatf("%s_m1_%0d", tag, i), cap1[i].v, 16'(m1[i / W]));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; pixel_in = '0;
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_hold");
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle("after_reset");

        // Pixels without in_sof in IDLE are dropped.
        clear_mon();
        repeat (3) send_pixel(int'($urandom_range(0, 4095)), 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("drop_out0", cap0.size(), 0);
        chk("drop_out1", cap1.size(), 0);

        // Flat rows 10/20/40.
        row_frame(10, 20, 40);
        run_frame("flat", 1'b0, 1'b0);
        check_rows("flat_spec", 0, 15, 0, 5, 15, 10);

        // Sign and floor corners in row 1 of the BORDER_MODE 0 instance.
        rand_frame();
        frm[0][0] = 21;   frm[2][0] = 20;
        frm[0][1] = 0;    frm[2][1] = 4095;
        frm[0][2] = 4095; frm[2][2] = 0;
        run_frame("sign", 1'b0, 1'b0);
        if (cap0.size() > 6) begin
            chk("sign_m1", cap0[4].v, 16'hFFFF);
            chk("sign_p2047", cap0[5].v, 16'h07FF);
            chk("sign_m2048", cap0[6].v, 16'hF800);
        end else begin
            chk("sign_count", cap0.size(), 12);
        end

        // Random frames, gap-free and then with gaps plus ignored flush pixels.
        for (int k = 0; k < 4; k++) begin
            rand_frame();
            run_frame($sformatf("rnd%0d_plain", k), 1'b0, 1'b0);
            run_frame($sformatf("rnd%0d_gaps", k), 1'b1, 1'b1);
        end

        // Abort: new in_sof at row 1 col 2.
        clear_mon();
        rand_frame();
        push_exp(0, 0);
        push_exp(0, 1);
        for (int c = 0; c < W; c++) send_pixel(frm[0][c], (c == 0), 1'b0);
        send_pixel(frm[1][0], 1'b0, 1'b0);
        send_pixel(frm[1][1], 1'b0, 1'b0);
        rand_frame();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) push_exp(r, c);
        send_frame(1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        compare_caps("abort");
        chk("abort_err0", errc0, 1);
        chk("abort_err1", errc1, 1);
        chk("abort_rdylow0", low0, W);

        // Reset mid-RUN.
        clear_mon();
        rand_frame();
        for (int i = 0; i < 6; i++) send_pixel(frm[i / W][i % W], (i == 0), 1'b0);
        reset = 1'b1;
        #2;
        check_idle("rst_run_async");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle("rst_run_next");
        row_frame(10, 20, 40);
        run_frame("after_rst_run", 1'b0, 1'b0);
        check_rows("after_rst_run_spec", 0, 15, 0, 5, 15, 10);

        // Reset mid-FLUSH.
        clear_mon();
        rand_frame();
        send_frame(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check_idle("rst_flush_async");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle("rst_flush_next");
        row_frame(10, 20, 40);
        run_frame("after_rst_flush", 1'b0, 1'b0);
        check_rows("after_rst_flush_spec", 0, 15, 0, 5, 15, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
